// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU operand/opcode sequencer.
//   state_t      : FSM state encodings (values are visible on state_dbg)
//   OP_*         : ALU opcode values; anything above OP_LAST_LEGAL is illegal
//   op_legal()   : classifies a raw 4-bit opcode entry
package alu_op_sequencer_pkg;

  typedef enum logic [2:0] {
    S_GET_A   = 3'd0,
    S_GET_B   = 3'd1,
    S_GET_OP  = 3'd2,
    S_SETTLE  = 3'd3,
    S_CAPTURE = 3'd4
  } state_t;

  localparam logic [2:0] OP_INC        = 3'd0;
  localparam logic [2:0] OP_RIPPLE     = 3'd1;
  localparam logic [2:0] OP_ADD        = 3'd2;
  localparam logic [2:0] OP_XOROR      = 3'd3;
  localparam logic [2:0] OP_REDOR      = 3'd4;
  localparam logic [2:0] OP_CAT        = 3'd5;
  localparam logic [2:0] OP_LAST_LEGAL = OP_CAT;

  // The entry bus is 4 bits wide but opcodes are 3 bits; a set MSB is an
  // illegal entry rather than being silently truncated.
  function automatic logic op_legal(input logic [3:0] code);
    return (code[3] == 1'b0) && (code[2:0] <= OP_LAST_LEGAL);
  endfunction

endpackage

// File: rtl/alu_op_sequencer_enter_sync_edge.sv
// Synchronizes the asynchronous ENTER key and turns each rising edge into a
// single-cycle press pulse.
//   clk, resetn : clock, asynchronous active-low reset
//   enter       : raw active-high key level
//   press       : one-cycle pulse per synchronized rising edge
module enter_sync_edge
  import alu_op_sequencer_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic enter,
  output logic press
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  // Synchronizer and history reset to 1 so a key held down through reset
  // release looks like "already pressed" and yields no pulse until it is
  // released and pressed again.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q <= '1;
      hist_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], enter};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign press = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/alu_op_sequencer.sv
// Collects operand A, operand B and an opcode from a shared 4-bit entry bus
// over three ENTER presses, presents them to a combinational ALU, waits a
// settle window, and registers the 8-bit ALU result.
//   clk, resetn      : clock, asynchronous active-low reset
//   enter, data_in   : entry key and 4-bit value bus
//   chain            : at A-load, reuse result[3:0] as A when a result is held
//   alu_result       : combinational ALU output for (a_out, b_out, op_out)
//   a_out/b_out/op_out : registered ALU operands and opcode
//   alu_req          : ALU inputs stable and being evaluated
//   result, result_valid, err : captured result / completion / illegal opcode
//   busy, state_dbg  : status and raw FSM state
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 1,
  parameter int CHAIN_EN    = 1
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       enter,
  input  logic [3:0] data_in,
  input  logic       chain,
  input  logic [7:0] alu_result,
  output logic [3:0] a_out,
  output logic [3:0] b_out,
  output logic [2:0] op_out,
  output logic       alu_req,
  output logic [7:0] result,
  output logic       result_valid,
  output logic       err,
  output logic       busy,
  output logic [2:0] state_dbg
);

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt;
  logic       press;
  logic       take_chain;

  enter_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_enter (
    .clk    (clk),
    .resetn (resetn),
    .enter  (enter),
    .press  (press)
  );

  assign take_chain = chain && (CHAIN_EN != 0) && result_valid;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_GET_A;
    else         state <= state_nxt;
  end

  // Presses arriving while the ALU is settling or being captured are dropped.
  always_comb begin
    state_nxt = state;
    alu_req   = 1'b0;
    case (state)
      S_GET_A:   if (press) state_nxt = S_GET_B;
      S_GET_B:   if (press) state_nxt = S_GET_OP;
      S_GET_OP:  if (press) state_nxt = op_legal(data_in) ? S_SETTLE : S_GET_A;
      S_SETTLE: begin
        alu_req = 1'b1;
        if (cnt == HOLD_LAST) state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        alu_req   = 1'b1;
        state_nxt = S_GET_A;
      end
      default:   state_nxt = S_GET_A;
    endcase
  end

  // Operand, result and flag registers; operands stay frozen from settle
  // entry through capture because only GET_* states with a press write them.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      a_out        <= '0;
      b_out        <= '0;
      op_out       <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      err          <= 1'b0;
      cnt          <= '0;
    end else begin
      case (state)
        S_GET_A: if (press) begin
          a_out        <= take_chain ? result[3:0] : data_in;
          result_valid <= 1'b0;
          err          <= 1'b0;
        end
        S_GET_B: if (press) b_out <= data_in;
        S_GET_OP: if (press) begin
          if (op_legal(data_in)) begin
            op_out <= data_in[2:0];
            cnt    <= '0;
          end else begin
            err    <= 1'b1;
          end
        end
        S_SETTLE:  cnt <= cnt + 4'd1;
        S_CAPTURE: begin
          result       <= alu_result;
          result_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != S_GET_A);
  assign state_dbg = state;

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;

  localparam int SYNC = 2;
  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       enter = 1'b0;
  logic       chain = 1'b0;
  logic [3:0] data_in = 4'h0;
  logic [7:0] alu_result;
  logic [3:0] a_out, b_out;
  logic [2:0] op_out;
  logic       alu_req, result_valid, err, busy;
  logic [7:0] result;
  logic [2:0] state_dbg;

  int n_vec = 0;
  int n_err = 0;
  int req_hi = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(
    .SYNC_STAGES (SYNC),
    .HOLD_CYCLES (HOLD),
    .CHAIN_EN    (1)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .enter        (enter),
    .data_in      (data_in),
    .chain        (chain),
    .alu_result   (alu_result),
    .a_out        (a_out),
    .b_out        (b_out),
    .op_out       (op_out),
    .alu_req      (alu_req),
    .result       (result),
    .result_valid (result_valid),
    .err          (err),
    .busy         (busy),
    .state_dbg    (state_dbg)
  );

  function automatic logic [7:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                        input logic [2:0] op);
    case (op)
      3'd0:    return {4'h0, a} + 8'd1;
      3'd1:    return {4'h0, a} + {4'h0, b};
      3'd2:    return {4'h0, a} + {4'h0, b};
      3'd3:    return {a | b, a ^ b};
      3'd4:    return {7'd0, |{a, b}};
      3'd5:    return {a, b};
      default: return 8'h00;
    endcase
  endfunction

  // Environment ALU driven by the sequencer's operands
  assign alu_result = alu_fn(a_out, b_out, op_out);

  // Behavioural model: phase 0/1/2 = waiting for A/B/opcode, 3 = executing
  // with m_left cycles until the result is taken.
  int         m_phase;
  int         m_left;
  logic [3:0] m_a, m_b;
  logic [2:0] m_op;
  logic [7:0] m_res;
  logic       m_rv, m_err;
  logic       smp [0:SYNC];

  always @(posedge clk) begin
    if (!resetn) begin
      m_phase = 0; m_left = 0; m_a = '0; m_b = '0; m_op = '0;
      m_res = '0; m_rv = 1'b0; m_err = 1'b0;
      for (int k = 0; k <= SYNC; k++) smp[k] = 1'b1;
    end else begin
      logic pr;
      pr = smp[SYNC-1] && !smp[SYNC];
      for (int k = SYNC; k > 0; k--) smp[k] = smp[k-1];
      smp[0] = enter;
      if (m_phase == 3) begin
        m_left--;
        if (m_left == 0) begin
          m_res = alu_fn(m_a, m_b, m_op);
          m_rv = 1'b1;
          m_phase = 0;
        end
      end else if (pr) begin
        case (m_phase)
          0: begin
            m_a = (chain && m_rv) ? m_res[3:0] : data_in;
            m_rv = 1'b0; m_err = 1'b0; m_phase = 1;
          end
          1: begin m_b = data_in; m_phase = 2; end
          default: begin
            if (data_in <= 4'd5) begin
              m_op = data_in[2:0]; m_left = HOLD + 1; m_phase = 3;
            end else begin
              m_err = 1'b1; m_phase = 0;
            end
          end
        endcase
      end
    end
  end

  function automatic logic [2:0] exp_state();
    if (m_phase < 3) return 3'(m_phase);
    return (m_left > 1) ? 3'd3 : 3'd4;
  endfunction

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (alu_req) req_hi++;
    check("a_out",        8'(a_out),        8'(m_a));
    check("b_out",        8'(b_out),        8'(m_b));
    check("op_out",       8'(op_out),       8'(m_op));
    check("result",       result,           m_res);
    check("result_valid", 8'(result_valid), 8'(m_rv));
    check("err",          8'(err),          8'(m_err));
    check("busy",         8'(busy),         8'(m_phase != 0));
    check("alu_req",      8'(alu_req),      8'(m_phase == 3));
    check("state_dbg",    8'(state_dbg),    8'(exp_state()));
  end

  task automatic press_key(input logic [3:0] v);
    @(negedge clk);
    data_in = v;
    enter = 1'b1;
    repeat (3) @(negedge clk);
    enter = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic settle_wait();
    repeat (HOLD + 4) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  lat;
    bit  done;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_state",  8'(state_dbg),    8'h00);
    check("rst_result", result,           8'h00);
    check("rst_rv",     8'(result_valid), 8'h00);
    check("rst_a",      8'(a_out),        8'h00);
    check("rst_busy",   8'(busy),         8'h00);
    resetn = 1'b1;
    repeat (3) @(negedge clk);

    // 1: basic add with latency measured from the opcode key edge
    press_key(4'd3);
    press_key(4'd4);
    @(negedge clk);
    data_in = 4'd2;
    enter = 1'b1;
    lat = 0;
    done = 1'b0;
    for (int i = 0; i < 30 && !done; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (result_valid) done = 1'b1;
    end
    @(negedge clk);
    enter = 1'b0;
    check("t1_latency", 8'(lat), 8'(SYNC + HOLD + 2));
    check("t1_result",  result, 8'h07);
    check("t1_rv",      8'(result_valid), 8'h01);
    repeat (3) @(negedge clk);

    // 2: chain A from previous result
    chain = 1'b1;
    press_key(4'hF);
    check("t2_chain_a", 8'(a_out), 8'h07);
    chain = 1'b0;
    press_key(4'd1);
    press_key(4'd0);
    settle_wait();
    check("t2_result", result, 8'h08);

    // 3: illegal opcode
    press_key(4'd1);
    press_key(4'd1);
    req_hi = 0;
    press_key(4'd6);
    settle_wait();
    check("t3_err",    8'(err),          8'h01);
    check("t3_state",  8'(state_dbg),    8'h00);
    check("t3_rv",     8'(result_valid), 8'h00);
    check("t3_req_hi", 8'(req_hi),       8'h00);

    // 4: press during settle is dropped
    press_key(4'd2);
    press_key(4'd3);
    @(negedge clk);
    data_in = 4'd1;
    enter = 1'b1;
    @(negedge clk);
    @(negedge clk);
    enter = 1'b0;
    @(negedge clk);
    data_in = 4'd9;
    enter = 1'b1;
    repeat (3) @(negedge clk);
    enter = 1'b0;
    settle_wait();
    check("t4_result", result,          8'h05);
    check("t4_a_kept", 8'(a_out),       8'h02);
    check("t4_state",  8'(state_dbg),   8'h00);
    press_key(4'd9);
    check("t4_next_a", 8'(a_out),       8'h09);
    check("t4_rv_clr", 8'(result_valid), 8'h00);

    // 5: reset mid-settle with enter held through release
    press_key(4'd5);
    @(negedge clk);
    data_in = 4'd3;
    enter = 1'b1;
    repeat (3) @(negedge clk);
    check("t5_in_settle", 8'(state_dbg), 8'h03);
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (10) @(negedge clk);
    check("t5_state",  8'(state_dbg),    8'h00);
    check("t5_rv",     8'(result_valid), 8'h00);
    check("t5_result", result,           8'h00);
    check("t5_a",      8'(a_out),        8'h00);
    enter = 1'b0;
    repeat (4) @(negedge clk);
    press_key(4'd6);
    check("t5_repress", 8'(state_dbg), 8'h01);
    check("t5_a_load",  8'(a_out),     8'h06);

    // 6: concatenate, then a long held key gives exactly one press
    press_key(4'hF);
    press_key(4'hF);
    check("t6_illegal_msb", 8'(err), 8'h01);
    press_key(4'hA);
    press_key(4'h5);
    press_key(4'h5);
    settle_wait();
    check("t6_result", result, 8'hA5);
    @(negedge clk);
    data_in = 4'd3;
    enter = 1'b1;
    repeat (100) @(negedge clk);
    check("t6_held_state", 8'(state_dbg), 8'h01);
    check("t6_held_a",     8'(a_out),     8'h03);
    enter = 1'b0;
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
